// File: rtl/var_latency_adder.sv
// var_latency_adder: segmented adder whose carries settle one segment
// boundary per cycle. The result is released as soon as the segment
// carry vector stops changing, so latency follows the real carry chain.
// Operands arrive and results leave over valid/ready handshakes, and the
// result is held in registers until the consumer takes it.
module var_latency_adder #(
  parameter  int WIDTH = 32,
  parameter  int SEG_W = 8,
  localparam int SEGS  = WIDTH / SEG_W,
  localparam int LAT_W = $clog2(SEGS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             force_worst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [LAT_W-1:0] lat
);

  // Refuse to build when the operand does not split into whole segments.
  if ((SEG_W < 1) || (WIDTH < SEG_W) || ((WIDTH % SEG_W) != 0)) begin : g_width_check
    $error("var_latency_adder: WIDTH must be a positive multiple of SEG_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             force_q;
  logic [SEGS-1:0]  seg_cin_q;
  logic [SEGS-1:0]  seg_cin_d;
  logic [LAT_W-1:0] iter_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [LAT_W-1:0] lat_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] seg_sum_s;
  logic [SEGS-1:0]  seg_co_s;
  logic             stable_s;
  logic             finish_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             release_s;

  // Each segment is an independent single-cycle ripple add fed by its
  // currently assumed carry-in.
  for (genvar j = 0; j < SEGS; j++) begin : g_seg
    assign {seg_co_s[j], seg_sum_s[j*SEG_W +: SEG_W]} =
        (SEG_W+1)'(a_q[j*SEG_W +: SEG_W]) +
        (SEG_W+1)'(b_q[j*SEG_W +: SEG_W]) +
        (SEG_W+1)'(seg_cin_q[j]);
  end

  // Next carry vector: boundary j+1 takes segment j's carry-out; the
  // external carry-in at boundary 0 never changes during evaluation.
  always_comb begin
    seg_cin_d = seg_cin_q;
    for (int j = 0; j < SEGS - 1; j++) begin
      seg_cin_d[j+1] = seg_co_s[j];
    end
    stable_s = (seg_cin_d == seg_cin_q);
    finish_s = (stable_s && !force_q) || (iter_q == LAT_W'(SEGS));
  end

  // Handshake qualifiers; in HOLD the input side follows the output side
  // so a new add can start on the very edge the old result is taken.
  always_comb begin
    in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    accept_s   = in_valid && in_ready_s;
    release_s  = (state_q == ST_HOLD) && out_valid_q && out_ready;
  end

  // Operand capture on every accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      force_q <= 1'b0;
    end else if (accept_s) begin
      a_q     <= a;
      b_q     <= b;
      force_q <= force_worst;
    end else begin
      a_q     <= a_q;
      b_q     <= b_q;
      force_q <= force_q;
    end
  end

  // Control FSM: carry iteration, completion detection and result holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      seg_cin_q   <= '0;
      iter_q      <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      lat_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            seg_cin_q <= SEGS'(cin);
            iter_q    <= LAT_W'(1);
            state_q   <= ST_EVAL;
          end else begin
            state_q   <= ST_IDLE;
          end
        end
        ST_EVAL: begin
          if (finish_s) begin
            sum_q       <= seg_sum_s;
            cout_q      <= seg_co_s[SEGS-1];
            lat_q       <= iter_q;
            out_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end else begin
            seg_cin_q   <= seg_cin_d;
            iter_q      <= iter_q + LAT_W'(1);
            state_q     <= ST_EVAL;
          end
        end
        ST_HOLD: begin
          if (release_s) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              seg_cin_q <= SEGS'(cin);
              iter_q    <= LAT_W'(1);
              state_q   <= ST_EVAL;
            end else begin
              state_q   <= ST_IDLE;
            end
          end else begin
            state_q <= ST_HOLD;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign lat       = lat_q;

endmodule

// File: tb/tb_var_latency_adder.sv
// Bench for var_latency_adder: six parameter sets side by side; directed
// scenarios use the 32/8 instance, the random run visits every instance.
module tb_var_latency_adder;

  localparam int NCFG       = 6;
  localparam int DC         = 3;     // WIDTH=32, SEG_W=8 instance
  localparam int N_PER_CFG  = 1667;
  localparam int RAND_LIMIT = 30000;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCFG-1:0]  iv_a  = '0;
  logic [63:0]      ra    = '0;
  logic [63:0]      rb    = '0;
  logic             ci    = 1'b0;
  logic             fw    = 1'b0;
  logic             ordy  = 1'b0;

  logic [NCFG-1:0]        ir_w;
  logic [NCFG-1:0]        ov_w;
  logic [NCFG-1:0]        co_w;
  logic [NCFG-1:0][63:0]  s_w;
  logic [NCFG-1:0][4:0]   l_w;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int W  = 16 << (gi / 2);
    localparam int S  = ((gi % 2) == 0) ? 4 : 8;
    localparam int LW = $clog2(W / S + 1);
    logic [W-1:0]  sum_l;
    logic [LW-1:0] lat_l;

    var_latency_adder #(.WIDTH(W), .SEG_W(S)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (iv_a[gi]),
      .in_ready    (ir_w[gi]),
      .a           (ra[W-1:0]),
      .b           (rb[W-1:0]),
      .cin         (ci),
      .force_worst (fw),
      .out_valid   (ov_w[gi]),
      .out_ready   (ordy),
      .sum         (sum_l),
      .cout        (co_w[gi]),
      .lat         (lat_l)
    );

    assign s_w[gi] = 64'(sum_l);
    assign l_w[gi] = 5'(lat_l);
  end

  // Reference: exact sum from wide arithmetic; latency from the longest
  // carry chain (distance from the generating segment, or from cin, to
  // each boundary that truly carries), plus one cycle to see it settle.
  function automatic void ref_add(input int w, input int sg,
                                  input logic [63:0] a_v, input logic [63:0] b_v,
                                  input logic c_v, input logic fw_v,
                                  output logic [63:0] s_o, output logic c_o,
                                  output int l_o);
    logic [64:0] one;
    logic [64:0] mask, am, bm, full, lm, t, sm;
    int segs, maxd, d;
    one  = 65'd1;
    mask = (one << w) - one;
    am   = {1'b0, a_v} & mask;
    bm   = {1'b0, b_v} & mask;
    full = am + bm + 65'(c_v);
    s_o  = full[63:0] & mask[63:0];
    c_o  = full[w];
    segs = w / sg;
    sm   = (one << sg) - one;
    maxd = 0;
    for (int j = 1; j < segs; j++) begin
      lm = (one << (j * sg)) - one;
      t  = (am & lm) + (bm & lm) + 65'(c_v);
      if (t[j*sg]) begin
        d = j;
        for (int i = j - 1; i >= 0; i--) begin
          if ((((am >> (i * sg)) & sm) + ((bm >> (i * sg)) & sm)) > sm) begin
            d = j - i;
            break;
          end
        end
        if (d > maxd) maxd = d;
      end
    end
    l_o = fw_v ? segs : (1 + maxd);
  endfunction

  // Offer one operand set to instance cfg and return just after acceptance.
  task automatic send_op(input logic [63:0] a_v, input logic [63:0] b_v,
                         input logic c_v, input logic fw_v, input int cfg);
    @(negedge clk);
    ra = a_v; rb = b_v; ci = c_v; fw = fw_v;
    iv_a = NCFG'(1) << cfg;
    #1;
    for (int k = 0; k < 40 && !ir_w[cfg]; k++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    iv_a = '0;
  endtask

  // Count rising edges until out_valid shows; -1 when it never does.
  task automatic wait_valid(input int cfg, output int cyc);
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (ov_w[cfg]) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    n_vec++; if (ov_w[DC] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", ov_w[DC]); end
    n_vec++; if (s_w[DC] !== 64'h0) begin n_err++; $display("FAIL reset_sum got=%h exp=0", s_w[DC]); end
    n_vec++; if (co_w[DC] !== 1'b0) begin n_err++; $display("FAIL reset_cout got=%b exp=0", co_w[DC]); end
    n_vec++; if (l_w[DC] !== 5'd0) begin n_err++; $display("FAIL reset_lat got=%0d exp=0", l_w[DC]); end
    n_vec++; if (ir_w[DC] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", ir_w[DC]); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] ta [4] = '{32'h00000001, 32'h000000FF, 32'hFFFFFFFF, 32'h00000001};
    logic [31:0] tb [4] = '{32'h00000002, 32'h00000001, 32'h00000000, 32'h00000002};
    logic        tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        tf [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] es [4] = '{32'h00000003, 32'h00000100, 32'h00000000, 32'h00000003};
    logic        ec [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int          el [4] = '{1, 2, 4, 4};
    int cyc;
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_op({32'h0, ta[i]}, {32'h0, tb[i]}, tc[i], tf[i], DC);
      wait_valid(DC, cyc);
      n_vec++; if (cyc !== el[i]) begin n_err++; $display("FAIL basic%0d_latency got=%0d exp=%0d", i, cyc, el[i]); end
      n_vec++; if (s_w[DC] !== {32'h0, es[i]}) begin n_err++; $display("FAIL basic%0d_sum got=%h exp=%h", i, s_w[DC], es[i]); end
      n_vec++; if (co_w[DC] !== ec[i]) begin n_err++; $display("FAIL basic%0d_cout got=%b exp=%b", i, co_w[DC], ec[i]); end
      n_vec++; if (l_w[DC] !== 5'(el[i])) begin n_err++; $display("FAIL basic%0d_lat got=%0d exp=%0d", i, l_w[DC], el[i]); end
    end
  endtask

  task automatic test_reset_mid_eval();
    logic stale;
    ordy = 1'b1;
    send_op(64'hFFFFFFFF, 64'h1, 1'b0, 1'b0, DC);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if (ov_w[DC] !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got=%b exp=0", ov_w[DC]); end
    n_vec++; if (s_w[DC] !== 64'h0) begin n_err++; $display("FAIL midrst_sum got=%h exp=0", s_w[DC]); end
    n_vec++; if (l_w[DC] !== 5'd0) begin n_err++; $display("FAIL midrst_lat got=%0d exp=0", l_w[DC]); end
    n_vec++; if (co_w[DC] !== 1'b0) begin n_err++; $display("FAIL midrst_cout got=%b exp=0", co_w[DC]); end
    n_vec++; if (ir_w[DC] !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got=%b exp=1", ir_w[DC]); end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (ov_w[DC]) stale = 1'b1;
    end
    n_vec++; if (stale !== 1'b0) begin n_err++; $display("FAIL midrst_stale_result got=%b exp=0", stale); end
    n_vec++; if (ir_w[DC] !== 1'b1) begin n_err++; $display("FAIL midrst_ready_after got=%b exp=1", ir_w[DC]); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    ordy = 1'b0;
    send_op(64'hFF, 64'h1, 1'b0, 1'b0, DC);
    wait_valid(DC, cyc);
    n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL hold_first_latency got=%0d exp=2", cyc); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (ov_w[DC] !== 1'b1 || s_w[DC] !== 64'h100 || l_w[DC] !== 5'd2 ||
          co_w[DC] !== 1'b0 || ir_w[DC] !== 1'b0) begin
        n_err++;
        $display("FAIL hold_stable%0d got ov=%b sum=%h lat=%0d cout=%b rdy=%b exp 1/100/2/0/0",
                 k, ov_w[DC], s_w[DC], l_w[DC], co_w[DC], ir_w[DC]);
      end
    end
    @(negedge clk);
    ordy = 1'b1;
    ra = 64'h80000000; rb = 64'h80000000; ci = 1'b0; fw = 1'b0;
    iv_a = NCFG'(1) << DC;
    #1;
    n_vec++; if (ir_w[DC] !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got=%b exp=1", ir_w[DC]); end
    @(posedge clk);
    #1;
    iv_a = '0;
    n_vec++; if (ov_w[DC] !== 1'b0) begin n_err++; $display("FAIL b2b_valid_drop got=%b exp=0", ov_w[DC]); end
    wait_valid(DC, cyc);
    n_vec++; if (cyc !== 1) begin n_err++; $display("FAIL b2b_latency got=%0d exp=1", cyc); end
    n_vec++; if (s_w[DC] !== 64'h0) begin n_err++; $display("FAIL b2b_sum got=%h exp=0", s_w[DC]); end
    n_vec++; if (co_w[DC] !== 1'b1) begin n_err++; $display("FAIL b2b_cout got=%b exp=1", co_w[DC]); end
    n_vec++; if (l_w[DC] !== 5'd1) begin n_err++; $display("FAIL b2b_lat got=%0d exp=1", l_w[DC]); end
  endtask

  task automatic test_random();
    logic [63:0] exp_s [$];
    logic        exp_c [$];
    int          exp_l [$];
    logic [63:0] es;
    logic        ec;
    int          el, w, sg, sent, cyc;
    ordy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < NCFG; c++) begin
      w = 16 << (c / 2);
      sg = ((c % 2) == 0) ? 4 : 8;
      exp_s.delete(); exp_c.delete(); exp_l.delete();
      sent = 0;
      cyc = 0;
      while ((sent < N_PER_CFG || exp_s.size() != 0) && cyc < RAND_LIMIT) begin
        @(negedge clk);
        cyc++;
        ra = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) rb = ~ra ^ 64'($urandom_range(0, 1));
        else rb = {$urandom, $urandom};
        ci   = 1'($urandom_range(0, 1));
        fw   = ($urandom_range(0, 7) == 0);
        ordy = ($urandom_range(0, 3) != 0);
        iv_a = (sent < N_PER_CFG && $urandom_range(0, 3) != 0) ? (NCFG'(1) << c) : '0;
        #1;
        if (ov_w[c] && ordy) begin
          n_vec++;
          if (exp_s.size() == 0) begin
            n_err++;
            $display("FAIL rand_unexpected cfg=%0d got sum=%h", c, s_w[c]);
          end else begin
            es = exp_s.pop_front();
            ec = exp_c.pop_front();
            el = exp_l.pop_front();
            if (s_w[c] !== es || co_w[c] !== ec || l_w[c] !== 5'(el)) begin
              n_err++;
              $display("FAIL rand_result cfg=%0d got sum=%h cout=%b lat=%0d exp sum=%h cout=%b lat=%0d",
                       c, s_w[c], co_w[c], l_w[c], es, ec, el);
            end
          end
        end
        if (iv_a[c] && ir_w[c]) begin
          ref_add(w, sg, ra, rb, ci, fw, es, ec, el);
          exp_s.push_back(es);
          exp_c.push_back(ec);
          exp_l.push_back(el);
          sent++;
        end
      end
      iv_a = '0;
      n_vec++;
      if (sent !== N_PER_CFG || exp_s.size() !== 0) begin
        n_err++;
        $display("FAIL rand_timeout cfg=%0d got sent=%0d pending=%0d exp sent=%0d pending=0",
                 c, sent, exp_s.size(), N_PER_CFG);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_eval();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
